// File: rtl/vector_checker_pkg.sv
// Shared types and the reference operation for the vector response checker.
package vector_checker_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_t;

    localparam int OP_AND = 0;
    localparam int OP_OR  = 1;
    localparam int OP_XOR = 2;
    localparam int OP_ADD = 3;

    // Full-width result; callers truncate to their operand width, which drops the ADD carry.
    function automatic logic [31:0] ref_op(input int op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_ADD:  return a + b;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and first-word fall-through read data.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; only pointers and occupancy are.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vector_checker.sv
// Response checker: buffers {a,b,c} samples, compares c against a reference op,
// and reports counts, pass/fail and the first mismatch of each run.
module vector_checker
    import vector_checker_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int N_VECTORS  = 8,
    parameter int OP         = OP_AND,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = $clog2(N_VECTORS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CW-1:0]    sample_count,
    output logic [CW-1:0]    error_count,
    output logic             first_err_valid,
    output logic [CW-1:0]    first_err_idx,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_act
);

    chk_state_t         state, state_nxt;
    logic [CW-1:0]      accepted;
    logic               push, pop;
    logic               fifo_full, fifo_empty;
    logic [3*WIDTH-1:0] fifo_rdata;
    logic [WIDTH-1:0]   pop_a, pop_b, pop_c, exp_c;
    logic               mismatch, last_pop, enter_run;

    sync_fifo #(
        .WIDTH(3 * WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata({in_a, in_b, in_c}),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Full flag is registered, so a same-cycle pop never lets a new sample through.
    assign in_ready  = (state == RUN) && !fifo_full && (accepted < CW'(N_VECTORS));
    assign push      = in_valid && in_ready;
    assign pop       = !fifo_empty;
    assign busy      = (state == RUN);

    // ---- compare stage: head of FIFO against reference ----
    assign {pop_a, pop_b, pop_c} = fifo_rdata;
    assign exp_c     = WIDTH'(ref_op(OP, 32'(pop_a), 32'(pop_b)));
    assign mismatch  = pop && (exp_c != pop_c);
    assign last_pop  = pop && (sample_count == CW'(N_VECTORS - 1));
    assign enter_run = (state_nxt == RUN) && (state != RUN);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)    state_nxt = RUN;
            RUN:     if (last_pop) state_nxt = DONE;
            DONE:    if (start)    state_nxt = RUN;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accepted        <= '0;
            sample_count    <= '0;
            error_count     <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_exp   <= '0;
            first_err_act   <= '0;
        end else if (enter_run) begin
            accepted        <= '0;
            sample_count    <= '0;
            error_count     <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_exp   <= '0;
            first_err_act   <= '0;
        end else begin
            if (push)
                accepted <= accepted + 1'b1;
            if (pop)
                sample_count <= sample_count + 1'b1;
            if (mismatch)
                error_count <= error_count + 1'b1;
            if (mismatch && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= sample_count;
                first_err_exp   <= exp_c;
                first_err_act   <= pop_c;
            end
            if (last_pop) begin
                done <= 1'b1;
                pass <= (error_count == '0) && !mismatch;
            end
        end
    end

endmodule

// File: tb/tb_vector_checker.sv
// Scoreboard bench for vector_checker: an AND instance and an ADD instance share clock and reset.
module tb_vector_checker;

    localparam int W  = 4;
    localparam int N  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]    start, in_valid, in_ready, busy, done, pass, fev;
    logic [W-1:0]  in_a [2];
    logic [W-1:0]  in_b [2];
    logic [W-1:0]  in_c [2];
    logic [W-1:0]  fe_exp [2];
    logic [W-1:0]  fe_act [2];
    logic [CW-1:0] scnt [2];
    logic [CW-1:0] ecnt [2];
    logic [CW-1:0] fe_idx [2];

    vector_checker #(.WIDTH(W), .N_VECTORS(N), .OP(0), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_c(in_c[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .sample_count(scnt[0]), .error_count(ecnt[0]),
        .first_err_valid(fev[0]), .first_err_idx(fe_idx[0]),
        .first_err_exp(fe_exp[0]), .first_err_act(fe_act[0])
    );

    vector_checker #(.WIDTH(W), .N_VECTORS(N), .OP(3), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_c(in_c[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .sample_count(scnt[1]), .error_count(ecnt[1]),
        .first_err_valid(fev[1]), .first_err_idx(fe_idx[1]),
        .first_err_exp(fe_exp[1]), .first_err_act(fe_act[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    int stalls   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour straight from the operation table.
    function automatic logic [W-1:0] model_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        int r;
        case (op)
            0:       r = int'(a & b);
            1:       r = int'(a | b);
            2:       r = int'(a ^ b);
            default: r = int'(a) + int'(b);
        endcase
        return W'(r % (1 << W));
    endfunction

    typedef struct {
        int           d;
        logic [W-1:0] exp;
        logic [W-1:0] act;
    } sb_t;

    sb_t sbq[$];
    sb_t e;

    int           mdl_cnt [2];
    int           mdl_err [2];
    int           mdl_fidx [2];
    logic [W-1:0] mdl_fexp [2];
    logic [W-1:0] mdl_fact [2];
    logic [1:0]   prev_busy, prev_done;
    logic [CW-1:0] prev_cnt [2];

    // Monitor: every sample_count step consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            prev_busy = '0;
            prev_done = '0;
            for (int d = 0; d < 2; d++) begin
                mdl_cnt[d] = 0; mdl_err[d] = 0; prev_cnt[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (busy[d] && !prev_busy[d]) begin
                    mdl_cnt[d] = 0; mdl_err[d] = 0; prev_cnt[d] = '0;
                    check("entry_cnt", scnt[d], 0);
                    check("entry_err", ecnt[d], 0);
                    check("entry_fev", fev[d], 0);
                    check("entry_done", done[d], 0);
                end
                if (scnt[d] != prev_cnt[d]) begin
                    check("sb_pending", (sbq.size() > 0 && sbq[0].d == d), 1);
                    if (sbq.size() > 0 && sbq[0].d == d) begin
                        e = sbq.pop_front();
                        if (e.exp != e.act) begin
                            if (mdl_err[d] == 0) begin
                                mdl_fidx[d] = mdl_cnt[d]; mdl_fexp[d] = e.exp; mdl_fact[d] = e.act;
                            end
                            mdl_err[d]++;
                        end
                        mdl_cnt[d]++;
                        check("sample_count", scnt[d], mdl_cnt[d]);
                        check("error_count", ecnt[d], mdl_err[d]);
                        check("first_err_valid", fev[d], mdl_err[d] > 0);
                        if (mdl_err[d] > 0) begin
                            check("first_err_idx", fe_idx[d], mdl_fidx[d]);
                            check("first_err_exp", fe_exp[d], mdl_fexp[d]);
                            check("first_err_act", fe_act[d], mdl_fact[d]);
                        end
                    end
                end
                if (done[d] && !prev_done[d]) begin
                    check("done_pass", pass[d], mdl_err[d] == 0);
                    check("done_busy", busy[d], 0);
                    check("done_cnt", scnt[d], N);
                end
                prev_busy[d] = busy[d];
                prev_done[d] = done[d];
                prev_cnt[d]  = scnt[d];
            end
        end
    end

    // All stimulus tasks are entered and left 1 time unit after a rising edge.
    task automatic do_start(input int d);
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
    endtask

    task automatic send(input int d, input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c);
        int guard = 0;
        in_valid[d] = 1'b1; in_a[d] = a; in_b[d] = b; in_c[d] = c;
        while (!in_ready[d]) begin
            @(posedge clk); #1;
            stalls++; guard++;
            if (guard > 50) begin
                check("ready_timeout", guard, 0);
                in_valid[d] = 1'b0;
                return;
            end
        end
        @(posedge clk);
        sbq.push_back('{d: d, exp: model_op(op, a, b), act: c});
        #1;
    endtask

    task automatic wait_done(input int d);
        int guard = 0;
        while (!done[d] && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check("done_timeout", done[d], 1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] av, bv, cv;
        logic [4:0]   wide;
        int           e_run, d, op;

        rst = 1'b1; start = '0; in_valid = '0;
        for (int i = 0; i < 2; i++) begin in_a[i] = '0; in_b[i] = '0; in_c[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", in_ready, 0);
        check("rst_pass", pass, 0);
        check("rst_cnt", scnt[0], 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Test 1: clean AND run, back-to-back
        do_start(0);
        stalls = 0;
        for (int i = 0; i < N; i++) begin av = W'(i); send(0, 0, av, ~av, av & ~av); end
        in_valid[0] = 1'b0;
        check("t1_stalls", stalls, 0);
        @(negedge clk); check("t1_done_early", done[0], 0);
        @(negedge clk); check("t1_done", done[0], 1);
        check("t1_cnt", scnt[0], 8);
        check("t1_err", ecnt[0], 0);
        check("t1_pass", pass[0], 1);
        @(posedge clk); #1;

        // Test 2: single error at index 5
        do_start(0);
        for (int i = 0; i < N; i++) begin av = W'(i); send(0, 0, av, ~av, (i == 5) ? 4'h1 : 4'h0); end
        in_valid[0] = 1'b0;
        wait_done(0);
        check("t2_err", ecnt[0], 1);
        check("t2_fev", fev[0], 1);
        check("t2_idx", fe_idx[0], 5);
        check("t2_exp", fe_exp[0], 0);
        check("t2_act", fe_act[0], 1);
        check("t2_pass", pass[0], 0);

        // Test 3: errors at 2 and 6, capture keeps the first
        do_start(0);
        for (int i = 0; i < N; i++) begin av = W'(i); send(0, 0, av, ~av, (i == 2 || i == 6) ? 4'h3 : 4'h0); end
        in_valid[0] = 1'b0;
        wait_done(0);
        check("t3_err", ecnt[0], 2);
        check("t3_idx", fe_idx[0], 2);
        check("t3_act", fe_act[0], 3);

        // Test 4: backpressure with the compare stage frozen
        force dut0.pop = 1'b0;
        do_start(0);
        stalls = 0;
        for (int i = 0; i < 4; i++) begin av = W'(i); send(0, 0, av, 4'h5, av & 4'h5); end
        in_valid[0] = 1'b0;
        check("t4_no_stall", stalls, 0);
        check("t4_ready_full", in_ready[0], 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("t4_ready_held", in_ready[0], 0);
        end
        check("t4_no_count", scnt[0], 0);
        release dut0.pop;
        check("t4_ready_at_pop", in_ready[0], 0);
        @(posedge clk); #1;
        check("t4_ready_resume", in_ready[0], 1);
        for (int i = 4; i < N; i++) begin av = W'(i); send(0, 0, av, 4'h5, av & 4'h5); end
        in_valid[0] = 1'b0;
        wait_done(0);
        check("t4_cnt", scnt[0], 8);
        check("t4_pass", pass[0], 1);

        // Test 5: ADD drops the carry
        do_start(1);
        send(1, 3, 4'hF, 4'h1, 4'h0);
        wide = 5'h10;
        send(1, 3, 4'hF, 4'h1, wide[3:0]);
        for (int i = 2; i < N; i++) begin
            av = W'($urandom); bv = W'($urandom);
            send(1, 3, av, bv, model_op(3, av, bv));
        end
        in_valid[1] = 1'b0;
        wait_done(1);
        check("t5_err", ecnt[1], 0);
        check("t5_pass", pass[1], 1);

        // Test 6: reset mid-run, idle input ignored, start mid-run ignored
        do_start(0);
        for (int i = 0; i < 3; i++) begin av = W'(i); send(0, 0, av, av, av); end
        in_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_busy", busy[0], 0);
        check("t6_rst_cnt", scnt[0], 0);
        check("t6_rst_ready", in_ready[0], 0);
        check("t6_rst_done", done[0], 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid[0] = 1'b1; in_a[0] = 4'h3; in_b[0] = 4'h3; in_c[0] = 4'h3;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("t6_idle_ready", in_ready[0], 0);
        end
        in_valid[0] = 1'b0;
        check("t6_idle_cnt", scnt[0], 0);
        do_start(0);
        for (int i = 0; i < N; i++) begin
            av = W'(i);
            if (i == 4) start[0] = 1'b1;
            send(0, 0, av, 4'hC, av & 4'hC);
            start[0] = 1'b0;
        end
        in_valid[0] = 1'b0;
        wait_done(0);
        check("t6_cnt", scnt[0], 8);
        check("t6_pass", pass[0], 1);

        // Randomized runs on both instances with idle gaps
        for (int r = 0; r < 6; r++) begin
            d  = r % 2;
            op = (d == 1) ? 3 : 0;
            e_run = 0;
            do_start(d);
            for (int i = 0; i < N; i++) begin
                av = W'($urandom); bv = W'($urandom);
                cv = ($urandom_range(0, 3) == 0) ? W'($urandom) : model_op(op, av, bv);
                if (cv != model_op(op, av, bv)) e_run++;
                send(d, op, av, bv, cv);
                if ($urandom_range(0, 2) == 0) begin
                    in_valid[d] = 1'b0;
                    repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                end
            end
            in_valid[d] = 1'b0;
            wait_done(d);
            check("rnd_err", ecnt[d], e_run);
            check("rnd_pass", pass[d], e_run == 0);
        end

        @(posedge clk); #1;
        check("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
